weight_preload_dma: RTL and testbench

Upstream feeder for the weight loader: on a level-held `preload_req`, it copies `preload_count` consecutive DATA_W-bit words from external weight memory, starting at `preload_base`, into the on-chip weight buffer at addresses 0..count-1. It then pulses `preload_done`. It sits between the external memory read port and the write port of the weight BRAM whose read port the loader drains.

---
 rtl/weight_dma_pkg.sv | 20 ++
 rtl/wpl_credit_ctr.sv | 41 ++++
 rtl/weight_preload_dma.sv | 161 ++++++++++++++++
 tb/tb_weight_preload_dma.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_dma_pkg.sv
// rtl/weight_dma_pkg.sv - FSM encoding, counter width and buffer-depth helper for weight_preload_dma
package weight_dma_pkg;

  // Width of the count, issue and receive counters (covers preload_count).
  localparam int WPL_CNT_W = 17;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } wpl_state_t;

  // Buffer depth as a value one bit wider than the counters, so the clamp
  // compare stays exact for every legal buffer address width.
  function automatic logic [WPL_CNT_W:0] wpl_buf_depth(input int buf_addr_w);
    return (WPL_CNT_W + 1)'(1) << buf_addr_w;
  endfunction

endpackage

// File: rtl/wpl_credit_ctr.sv
// rtl/wpl_credit_ctr.sv - outstanding memory-read credit counter for weight_preload_dma
module wpl_credit_ctr #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             full,
  output logic             empty
);

  // Next value: a simultaneous issue and response leaves the count unchanged.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && !dec) begin
      count_nxt = count + CNT_W'(1);
    end else if (dec && !inc) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Credit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign full  = (count == CNT_W'(MAX_OUTST));
  assign empty = (count == '0);

endmodule

// File: rtl/weight_preload_dma.sv
// rtl/weight_preload_dma.sv - copies a block of external weight words into the weight buffer; WEIGHT_PRELOAD_CSUM_EN adds preload_csum
module weight_preload_dma
  import weight_dma_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 128,
  parameter int BUF_ADDR_W = 15,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  preload_req,
  input  logic [ADDR_W-1:0]     preload_base,
  input  logic [WPL_CNT_W-1:0]  preload_count,
  output logic                  preload_done,
  output logic                  preload_busy,
  output logic                  preload_err,
  output logic                  mem_rd_req,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_rd_valid,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  buf_we,
  output logic [BUF_ADDR_W-1:0] buf_waddr,
  output logic [DATA_W-1:0]     buf_wdata
`ifdef WEIGHT_PRELOAD_CSUM_EN
  ,
  output logic [DATA_W-1:0]     preload_csum
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTST) + 1;

  wpl_state_t state, next_state;

  logic [ADDR_W-1:0]    base_r, base_nxt, addr_nxt;
  logic [WPL_CNT_W-1:0] count_r, count_nxt;
  logic [WPL_CNT_W-1:0] issued, issued_nxt;
  logic [WPL_CNT_W-1:0] received;
  logic [WPL_CNT_W:0]   buf_depth;
  logic [OUT_W-1:0]     outst, outst_nxt;
  logic                 outst_full, outst_empty;
  logic                 accept, clamp_hit, issue_hs, rsp_ok;
  logic                 req_nxt, done_nxt, busy_nxt;

  assign buf_depth = wpl_buf_depth(BUF_ADDR_W);
  assign accept    = (state == S_IDLE) && preload_req;
  assign clamp_hit = ({1'b0, preload_count} > buf_depth);
  assign issue_hs  = mem_rd_req && mem_rd_ready;
  // Responses are only legal while reads are in flight; anything else is a stray beat.
  assign rsp_ok    = mem_rd_valid && ((state == S_RUN) || (state == S_DRAIN)) && !outst_empty;

  wpl_credit_ctr #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (OUT_W)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .inc       (issue_hs),
    .dec       (rsp_ok),
    .count     (outst),
    .count_nxt (outst_nxt),
    .full      (outst_full),
    .empty     (outst_empty)
  );

  // Next state plus next values of the registered request, address and status outputs.
  always_comb begin
    next_state = state;
    base_nxt   = base_r;
    count_nxt  = count_r;
    issued_nxt = issued + WPL_CNT_W'(issue_hs);
    case (state)
      S_IDLE: begin
        if (preload_req) begin
          base_nxt   = preload_base;
          count_nxt  = clamp_hit ? buf_depth[WPL_CNT_W-1:0] : preload_count;
          issued_nxt = '0;
          // An empty job passes once through the drain check so that it
          // completes with the same two-cycle turnaround as the done path.
          next_state = (preload_count == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN:   if (issued == count_r) next_state = S_DRAIN;
      S_DRAIN: if (received == count_r) next_state = S_DONE;
      S_DONE:  if (!preload_req) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    addr_nxt = base_nxt + ADDR_W'(issued_nxt);
    req_nxt  = (next_state == S_RUN) && (issued_nxt < count_nxt) &&
               (outst_nxt < OUT_W'(MAX_OUTST));
    done_nxt = (next_state == S_DONE) && (state != S_DONE);
    busy_nxt = (next_state == S_RUN) || (next_state == S_DRAIN) || done_nxt;
  end

  // Control state, job parameters, issue counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      base_r       <= '0;
      count_r      <= '0;
      issued       <= '0;
      mem_rd_req   <= 1'b0;
      mem_rd_addr  <= '0;
      preload_done <= 1'b0;
      preload_busy <= 1'b0;
    end else begin
      state        <= next_state;
      base_r       <= base_nxt;
      count_r      <= count_nxt;
      issued       <= issued_nxt;
      mem_rd_req   <= req_nxt;
      mem_rd_addr  <= addr_nxt;
      preload_done <= done_nxt;
      preload_busy <= busy_nxt;
    end
  end

  // Write path: each accepted beat lands in the buffer one cycle later at the next index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      received  <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      buf_we <= rsp_ok;
      if (accept) begin
        received <= '0;
      end else if (rsp_ok) begin
        received  <= received + WPL_CNT_W'(1);
        buf_waddr <= received[BUF_ADDR_W-1:0];
        buf_wdata <= mem_rd_data;
      end
    end
  end

  // Sticky error: oversized job or a response beat nobody asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preload_err <= 1'b0;
    end else if ((accept && clamp_hit) || (mem_rd_valid && !rsp_ok)) begin
      preload_err <= 1'b1;
    end
  end

`ifdef WEIGHT_PRELOAD_CSUM_EN
  // Running XOR of the words written by the current job; holds after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preload_csum <= '0;
    end else if (accept) begin
      preload_csum <= '0;
    end else if (buf_we) begin
      preload_csum <= preload_csum ^ buf_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_weight_preload_dma.sv
// tb/tb_weight_preload_dma.sv - randomized self-checking bench for weight_preload_dma (WEIGHT_PRELOAD_CSUM_EN optional)
`timescale 1ns/1ps
module tb_weight_preload_dma;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 128;
  localparam int BUF_ADDR_W = 15;
  localparam int MAX_OUTST  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  preload_req = 1'b0;
  logic [ADDR_W-1:0]     preload_base = '0;
  logic [16:0]           preload_count = '0;
  logic                  preload_done, preload_busy, preload_err;
  logic                  mem_rd_req;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic                  mem_rd_ready = 1'b0;
  logic                  mem_rd_valid = 1'b0;
  logic [DATA_W-1:0]     mem_rd_data = '0;
  logic                  buf_we;
  logic [BUF_ADDR_W-1:0] buf_waddr;
  logic [DATA_W-1:0]     buf_wdata;
`ifdef WEIGHT_PRELOAD_CSUM_EN
  logic [DATA_W-1:0]     preload_csum;
`endif

  always #5 clk = ~clk;

  weight_preload_dma #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_ADDR_W(BUF_ADDR_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .preload_req(preload_req), .preload_base(preload_base), .preload_count(preload_count),
    .preload_done(preload_done), .preload_busy(preload_busy), .preload_err(preload_err),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata)
`ifdef WEIGHT_PRELOAD_CSUM_EN
    , .preload_csum(preload_csum)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] seed;

  // Reference job state: expected address/data streams follow from base and count alone.
  logic [ADDR_W-1:0] job_base = '0;
  int wr_idx = 0, issue_cnt = 0, done_cnt = 0, done_cyc = -1, last_we_cyc = -1;
  int we_total = 0, max_pend = 0;
  int lat_lo = 1, lat_hi = 1, ready_pct = 100;
  bit stray_req = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } pend_t;
  pend_t pend_q[$];

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = {13'b0, a};
    return {x * 32'h9E3779B1, seed ^ x, ~x, x + seed};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // External memory model and output monitor; all activity on the falling edge.
  initial begin
    bit prev_req, prev_hs, exp_we;
    logic [ADDR_W-1:0] prev_addr, exp_a;
    pend_t p;
    prev_req = 0; prev_hs = 0; exp_we = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && (buf_we || exp_we)) check("we_latency", buf_we, exp_we);
      if (buf_we) begin
        we_total++;
        last_we_cyc = cyc;
        check("buf_waddr", buf_waddr, wr_idx);
        check("buf_wdata", buf_wdata, mem_word(job_base + ADDR_W'(wr_idx)));
        wr_idx++;
      end
      if (preload_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rst_n && prev_req && !prev_hs) begin
        check("req_hold", mem_rd_req, 1'b1);
        check("addr_hold", mem_rd_addr, prev_addr);
      end
      mem_rd_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      exp_we = 1'b0;
      if (!rst_n) begin
        pend_q.delete();
      end else if (stray_req) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_word(ADDR_W'(seed));
        stray_req    = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_word(pend_q[0].addr);
        exp_we       = 1'b1;
        void'(pend_q.pop_front());
      end
      prev_req  = rst_n && mem_rd_req;
      prev_addr = mem_rd_addr;
      prev_hs   = prev_req && mem_rd_ready;
      if (prev_hs) begin
        exp_a = job_base + ADDR_W'(issue_cnt);
        check("issue_addr", mem_rd_addr, exp_a);
        issue_cnt++;
        p.addr = mem_rd_addr;
        p.due  = cyc + int'($urandom_range(lat_lo, lat_hi));
        pend_q.push_back(p);
        if (pend_q.size() > max_pend) max_pend = pend_q.size();
        check("outstanding_le_max", pend_q.size() <= MAX_OUTST, 1'b1);
      end
    end
  end

  task automatic start_job(input logic [ADDR_W-1:0] base, input int count,
                           input int llo, input int lhi, input int rpct);
    job_base = base; wr_idx = 0; issue_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_we_cyc = -1; max_pend = 0;
    lat_lo = llo; lat_hi = lhi; ready_pct = rpct;
    preload_req = 1'b1; preload_base = base; preload_count = 17'(count);
  endtask

  task automatic run_job(input string name, input logic [ADDR_W-1:0] base, input int count,
                         input int llo, input int lhi, input int rpct,
                         input bit hold, input bit exp_err);
    int acc, eff, budget;
    bit seen;
    logic [DATA_W-1:0] x;
    eff = (count > (1 << BUF_ADDR_W)) ? (1 << BUF_ADDR_W) : count;
    budget = eff * ((rpct < 100) ? 10 : 3) + 100;
    @(negedge clk); #1;
    start_job(base, count, llo, lhi, rpct);
    acc = cyc;
    @(negedge clk); #1;
    check({name, ":busy_rise"}, preload_busy, 1'b1);
    check({name, ":first_req"}, mem_rd_req, eff > 0);
    if (!hold) preload_req = 1'b0;
    seen = (done_cnt > 0);
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      seen = (done_cnt > 0);
    end
    check({name, ":done_seen"}, seen, 1'b1);
    @(negedge clk); #1;
    preload_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check({name, ":done_pulses"}, done_cnt, 1);
    check({name, ":writes"}, wr_idx, eff);
    check({name, ":issues"}, issue_cnt, eff);
    check({name, ":done_cycle"}, done_cyc, (eff > 0) ? last_we_cyc + 1 : acc + 2);
    check({name, ":err"}, preload_err, exp_err);
    check({name, ":busy_after"}, preload_busy, 1'b0);
    check({name, ":req_after"}, mem_rd_req, 1'b0);
`ifdef WEIGHT_PRELOAD_CSUM_EN
    x = '0;
    for (int i = 0; i < eff; i++) x = x ^ mem_word(base + ADDR_W'(i));
    check({name, ":csum"}, preload_csum, x);
`else
    x = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    preload_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int we0;
    seed = $urandom;
    repeat (3) @(negedge clk);
    #1;
    check("rst:done", preload_done, 1'b0);
    check("rst:busy", preload_busy, 1'b0);
    check("rst:err", preload_err, 1'b0);
    check("rst:req", mem_rd_req, 1'b0);
    check("rst:addr", mem_rd_addr, 0);
    check("rst:we", buf_we, 1'b0);
    rst_n = 1'b1;

    run_job("basic", 19'h00100, 8, 2, 2, 100, 1'b1, 1'b0);
    run_job("credit", ADDR_W'($urandom), 16, 10, 10, 100, 1'b1, 1'b0);
    check("credit:peak_outstanding", max_pend, MAX_OUTST);
    run_job("backpressure", ADDR_W'($urandom), $urandom_range(20, 60), 1, 5, 50, 1'b0, 1'b0);
    run_job("zero", ADDR_W'($urandom), 0, 1, 1, 100, 1'b1, 1'b0);
    run_job("wrap", 19'h7FFFE, 4, 1, 3, 100, 1'b1, 1'b0);
    run_job("random", ADDR_W'($urandom), $urandom_range(1, 100), 1, 4, 75, 1'b1, 1'b0);
    run_job("overflow", ADDR_W'($urandom), 40000, 1, 1, 100, 1'b1, 1'b1);

    do_reset();
    check("post_rst:err", preload_err, 1'b0);
    we0 = we_total;
    @(negedge clk); #1;
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("stray:err", preload_err, 1'b1);
    check("stray:no_we", we_total, we0);

    do_reset();
    @(negedge clk); #1;
    start_job(ADDR_W'($urandom), 20, 3, 3, 100);
    repeat (6) @(negedge clk);
    #1;
    rst_n = 1'b0;
    preload_req = 1'b0;
    #1;
    check("midrst:busy", preload_busy, 1'b0);
    check("midrst:req", mem_rd_req, 1'b0);
    check("midrst:we", buf_we, 1'b0);
    check("midrst:done", preload_done, 1'b0);
    check("midrst:err", preload_err, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("midrst:no_done", done_cnt, 0);
    rst_n = 1'b1;
    run_job("after_rst", ADDR_W'($urandom), 12, 1, 4, 60, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
